branch_predictor: RTL

- Dynamic branch predictor feeding the fetch stage. Consumes the controller's isBranchPredictMiss and the resolved-branch results from execute.
- Holds a direct-mapped BTB and a 2-bit saturating-counter BHT.
- Gives fetch a same-cycle prediction of the next PC.
- Trains on every resolved branch or jump and counts mispredicts.

---
 rtl/branch_predictor_pkg.sv | 36 +++
 rtl/branch_target_buffer.sv | 55 +++++
 rtl/branch_predictor.sv | 92 +++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: BHT counter encoding, BTB entry layout
// and the saturating-counter training function.
package branch_predictor_pkg;

    localparam int PC_W_DEFAULT = 32;
    localparam int BHT_INDEX_W  = 6;
    localparam int BTB_TAG_W    = PC_W_DEFAULT - BHT_INDEX_W - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_counter_e;

    typedef struct packed {
        logic                      valid;
        logic [BTB_TAG_W-1:0]      tag;
        logic [PC_W_DEFAULT-1:0]   target;
    } btb_entry_t;

    // Saturating 2-bit counter step toward the resolved direction
    function automatic bht_counter_e bht_train(input bht_counter_e cnt, input logic taken);
        bht_counter_e nxt;
        nxt = cnt;
        case (cnt)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer addressed by word address (PC[PC_W-1:2]).
// Valid bits clear asynchronously on reset; tag/target storage is unreset.
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_W = BHT_INDEX_W,
    parameter int PC_W    = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-3:0] lookup_word,
    output logic            hit,
    output logic [PC_W-1:0] hit_target,
    input  logic            write_en,
    input  logic [PC_W-3:0] write_word,
    input  logic [PC_W-1:0] write_target
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = PC_W - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [PC_W-1:0]    target_reg [ENTRIES];

    logic [INDEX_W-1:0] rd_idx;
    logic [INDEX_W-1:0] wr_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic [TAG_W-1:0]   wr_tag;

    assign rd_idx = lookup_word[INDEX_W-1:0];
    assign rd_tag = lookup_word[PC_W-3:INDEX_W];
    assign wr_idx = write_word[INDEX_W-1:0];
    assign wr_tag = write_word[PC_W-3:INDEX_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else if (write_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // An invalid entry never hits, so tag/target need no reset
    always_ff @(posedge clk) begin
        if (write_en) begin
            tag_reg[wr_idx]    <= wr_tag;
            target_reg[wr_idx] <= write_target;
        end
    end

    assign hit        = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);
    assign hit_target = target_reg[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit BHT, same-cycle next-PC
// prediction for fetch. Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into the BHT index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_W = BHT_INDEX_W,
    parameter int PC_W    = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetchPC,
    input  logic            isBranchPredictMiss,
    output logic            predictTaken,
    output logic [PC_W-1:0] predictedNextPC,
    input  logic            updateValid,
    input  logic [PC_W-1:0] updatePC,
    input  logic            updateTaken,
    input  logic [PC_W-1:0] updateTarget,
    output logic [31:0]     missCount
);

    localparam int ENTRIES = 1 << INDEX_W;

    bht_counter_e       bht_reg [ENTRIES];
    bht_counter_e       bht_rd_cnt;
    logic [INDEX_W-1:0] bht_rd_idx;
    logic [INDEX_W-1:0] bht_wr_idx;
    logic [31:0]        miss_count_reg;
    logic               btb_hit;
    logic [PC_W-1:0]    btb_target;
    logic               unused_update_lsbs;

    assign unused_update_lsbs = ^updatePC[1:0];

    branch_target_buffer #(
        .INDEX_W (INDEX_W),
        .PC_W    (PC_W)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_word  (fetchPC[PC_W-1:2]),
        .hit          (btb_hit),
        .hit_target   (btb_target),
        .write_en     (updateValid && updateTaken),
        .write_word   (updatePC[PC_W-1:2]),
        .write_target (updateTarget)
    );

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_W-1:0] ghr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_reg <= '0;
        end else if (updateValid) begin
            ghr_reg <= {ghr_reg[INDEX_W-2:0], updateTaken};
        end
    end

    // Write index uses the history before this update shifts it in
    assign bht_rd_idx = fetchPC[INDEX_W+1:2] ^ ghr_reg;
    assign bht_wr_idx = updatePC[INDEX_W+1:2] ^ ghr_reg;
`else
    assign bht_rd_idx = fetchPC[INDEX_W+1:2];
    assign bht_wr_idx = updatePC[INDEX_W+1:2];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_reg[i] <= WEAK_NT;
            end
        end else if (updateValid) begin
            bht_reg[bht_wr_idx] <= bht_train(bht_reg[bht_wr_idx], updateTaken);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count_reg <= '0;
        end else if (isBranchPredictMiss) begin
            miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    // Lookup reads registered state only, so a same-cycle update is seen next cycle
    assign bht_rd_cnt      = bht_reg[bht_rd_idx];
    assign predictTaken    = btb_hit && bht_rd_cnt[1] && !isBranchPredictMiss;
    assign predictedNextPC = predictTaken ? btb_target : fetchPC + PC_W'(4);
    assign missCount       = miss_count_reg;

endmodule
